ip_sdram_arbiter: RTL and testbench
===================================

Name: ip_sdram_arbiter

Overview:
- Shares the single ip_sdram command port between two requesters: port A (VDP VRAM, high priority) and port B (CPU-side / auxiliary).
- Generates the periodic auto-refresh request that is currently tied off at the ip_sdram bus_refresh input.
- Sits between the requesters and ip_sdram, in the ip_sdram clock domain.
- Routes read data back to whichever port issued the read.

Parameters:
- ACCESS_CYCLES, 6, cycles a read/write occupies ip_sdram, counted from the sdram_valid pulse; must be >= 2.
- REFRESH_CYCLES, 8, cycles a refresh occupies ip_sdram, counted from the sdram_refresh pulse; must be >= 2.
- REFRESH_INTERVAL, 640, cycles between refresh requests.

Ports:
- clk  in  1  arbiter and ip_sdram clock.
- reset_n  in  1  asynchronous active-low reset.
- sdram_init_busy  in  1  ip_sdram initialisation in progress.
- a_address  in  23  port A word address.
- a_valid  in  1  port A request.
- a_write  in  1  port A 1=write, 0=read.
- a_wdata  in  8  port A write data.
- a_ready  out  1  port A accept pulse.
- a_rdata  out  32  port A read data.
- a_rdata_en  out  1  port A read data strobe.
- b_address, b_valid, b_write, b_wdata, b_ready, b_rdata, b_rdata_en: same as the port A signals, for port B.
- sdram_address  out  23  to ip_sdram bus_address.
- sdram_valid  out  1  to ip_sdram bus_valid.
- sdram_write  out  1  to ip_sdram bus_write.
- sdram_refresh  out  1  to ip_sdram bus_refresh.
- sdram_wdata  out  8  to ip_sdram bus_wdata.
- sdram_rdata  in  32  from ip_sdram bus_rdata.
- sdram_rdata_en  in  1  from ip_sdram bus_rdata_en.

Behaviour:
- Clock is clk; reset is reset_n, asynchronous, active-low.
- Reset values: all outputs 0; state INIT; refresh counter = REFRESH_INTERVAL-1; refresh_pending=0; owner=A.
- Reset mid-access aborts the access immediately; no rdata_en is forwarded afterwards.

State machine:
- INIT:
  - Stays while sdram_init_busy=1.
  - Refresh counter held at reload value.
  - Ready outputs held at 0.
  - Goes to IDLE on the first cycle sdram_init_busy=0.
- IDLE:
  - Samples requests in cycle N.
  - Priority: refresh_pending > a_valid > b_valid.
  - Refresh granted in cycle N: in N+1, sdram_refresh=1 for one cycle, refresh_pending cleared, state BUSY with count REFRESH_CYCLES.
  - Port X granted in cycle N: in N+1, x_ready=1 and sdram_valid=1 for one cycle. The address, write and wdata registered in cycle N drive sdram_* in N+1. owner<=X, rd_outstanding<=~x_write. State BUSY with count ACCESS_CYCLES.
  - No request: remain IDLE, all strobes 0.
- BUSY:
  - Down-counter counts from the grant pulse cycle.
  - Returns to IDLE when the count reaches 0 and rd_outstanding=0.
  - A read whose data has not returned at expiry holds BUSY until sdram_rdata_en.
  - Requests are not sampled in BUSY.

Requester rules:
- Hold valid and the request fields stable until the ready pulse.
- Deassert valid, or present the next request, in the cycle after ready.

Read return:
- On sdram_rdata_en with rd_outstanding=1: x_rdata<=sdram_rdata and x_rdata_en=1 for one cycle on the owner port only, one cycle after sdram_rdata_en. rd_outstanding is cleared.
- The other port's rdata and rdata_en are unchanged.
- sdram_rdata_en with rd_outstanding=0 is ignored.

Refresh counter:
- Decrements every cycle outside INIT.
- At 0: reloads REFRESH_INTERVAL-1 and sets refresh_pending.
- If expiry coincides with a refresh grant clearing pending, set wins (pending stays 1).
- A second expiry while already pending leaves the flag at 1; refreshes do not accumulate.

Misc:
- sdram_valid and sdram_refresh are never high in the same cycle.
- sdram_init_busy rising outside INIT has no effect.

Optional Feature:
- Macro: SDRAM_ARB_ROUND_ROBIN_EN.
- Defined:
  - Between A and B, priority alternates: the port not served by the last A/B grant wins a simultaneous request.
  - last_port resets to B, so A wins the first tie.
  - Refresh still has top priority.
- Undefined: fixed priority, A always beats B.

Test Plan:
- sdram_init_busy=1 for 100 cycles with a_valid=1 -> no a_ready or sdram_valid until 2 cycles after busy falls; first grant is A.
- A read at 0x000123, model returns 0xDEADBEEF 4 cycles after sdram_valid -> a_rdata=0xDEADBEEF with a_rdata_en one cycle later; b_rdata_en stays 0; next grant no earlier than ACCESS_CYCLES after sdram_valid.
- a_valid and b_valid held continuously -> fixed priority: only A granted, every ACCESS_CYCLES+1 cycles. With SDRAM_ARB_ROUND_ROBIN_EN: grants alternate A,B,A,B.
- No requests for 2000 cycles after init -> sdram_refresh pulses at 640-cycle period; sdram_valid stays 0.
- Refresh pending coincides with a_valid and b_valid -> refresh issued first; A granted REFRESH_CYCLES+1 cycles later.
- Read whose data returns at cycle ACCESS_CYCLES+3 -> arbiter stays BUSY until then. Separately, reset_n pulsed low mid-BUSY -> all outputs 0 immediately, state INIT, the late rdata_en is not forwarded.

Source files
------------

// File: rtl/ip_sdram_arbiter.sv
// rtl/ip_sdram_arbiter.sv - two-port ip_sdram command arbiter with periodic auto-refresh
// SDRAM_ARB_ROUND_ROBIN_EN: alternate A/B priority on simultaneous requests (default: A always wins)
module ip_sdram_arbiter #(
  parameter int ACCESS_CYCLES    = 6,
  parameter int REFRESH_CYCLES   = 8,
  parameter int REFRESH_INTERVAL = 640
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sdram_init_busy,
  input  logic [22:0] a_address,
  input  logic        a_valid,
  input  logic        a_write,
  input  logic [7:0]  a_wdata,
  output logic        a_ready,
  output logic [31:0] a_rdata,
  output logic        a_rdata_en,
  input  logic [22:0] b_address,
  input  logic        b_valid,
  input  logic        b_write,
  input  logic [7:0]  b_wdata,
  output logic        b_ready,
  output logic [31:0] b_rdata,
  output logic        b_rdata_en,
  output logic [22:0] sdram_address,
  output logic        sdram_valid,
  output logic        sdram_write,
  output logic        sdram_refresh,
  output logic [7:0]  sdram_wdata,
  input  logic [31:0] sdram_rdata,
  input  logic        sdram_rdata_en
);

  localparam int BMAX = (ACCESS_CYCLES > REFRESH_CYCLES) ? ACCESS_CYCLES : REFRESH_CYCLES;
  localparam int BW   = $clog2(BMAX);
  localparam int RW   = $clog2(REFRESH_INTERVAL);
  localparam logic [BW-1:0] ACC_LOAD   = BW'(ACCESS_CYCLES - 1);
  localparam logic [BW-1:0] REF_LOAD   = BW'(REFRESH_CYCLES - 1);
  localparam logic [RW-1:0] REF_RELOAD = RW'(REFRESH_INTERVAL - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_BUSY} state_t;

  state_t        state;
  logic [BW-1:0] busy_cnt;
  logic [RW-1:0] ref_cnt;
  logic          refresh_pending;
  logic          rd_outstanding;
  logic          owner_b;
  logic          ref_expire;
  logic          idle;
  logic          grant_ref;
  logic          grant_a;
  logic          grant_b;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  logic          last_b;
`endif

  always_comb begin
    idle       = (state == S_IDLE);
    ref_expire = (state != S_INIT) && (ref_cnt == '0);
    grant_ref  = idle && refresh_pending;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    grant_a    = idle && !refresh_pending && a_valid && (!b_valid || last_b);
`else
    grant_a    = idle && !refresh_pending && a_valid;
`endif
    grant_b    = idle && !refresh_pending && b_valid && !grant_a;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_INIT;
      busy_cnt        <= '0;
      ref_cnt         <= REF_RELOAD;
      refresh_pending <= 1'b0;
      rd_outstanding  <= 1'b0;
      owner_b         <= 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      last_b          <= 1'b1;
`endif
      a_ready         <= 1'b0;
      a_rdata         <= '0;
      a_rdata_en      <= 1'b0;
      b_ready         <= 1'b0;
      b_rdata         <= '0;
      b_rdata_en      <= 1'b0;
      sdram_address   <= '0;
      sdram_valid     <= 1'b0;
      sdram_write     <= 1'b0;
      sdram_refresh   <= 1'b0;
      sdram_wdata     <= '0;
    end else begin
      a_ready       <= 1'b0;
      b_ready       <= 1'b0;
      a_rdata_en    <= 1'b0;
      b_rdata_en    <= 1'b0;
      sdram_valid   <= 1'b0;
      sdram_refresh <= 1'b0;

      if (state == S_INIT || ref_expire) ref_cnt <= REF_RELOAD;
      else                               ref_cnt <= ref_cnt - 1'b1;

      // a new expiry outranks the clear from a refresh grant in the same cycle
      if (ref_expire)     refresh_pending <= 1'b1;
      else if (grant_ref) refresh_pending <= 1'b0;

      if (sdram_rdata_en && rd_outstanding) begin
        rd_outstanding <= 1'b0;
        if (owner_b) begin
          b_rdata    <= sdram_rdata;
          b_rdata_en <= 1'b1;
        end else begin
          a_rdata    <= sdram_rdata;
          a_rdata_en <= 1'b1;
        end
      end

      case (state)
        S_INIT: begin
          if (!sdram_init_busy) state <= S_IDLE;
        end
        S_IDLE: begin
          if (grant_ref) begin
            sdram_refresh <= 1'b1;
            busy_cnt      <= REF_LOAD;
            state         <= S_BUSY;
          end else if (grant_a) begin
            a_ready        <= 1'b1;
            sdram_valid    <= 1'b1;
            sdram_address  <= a_address;
            sdram_write    <= a_write;
            sdram_wdata    <= a_wdata;
            owner_b        <= 1'b0;
            rd_outstanding <= !a_write;
            busy_cnt       <= ACC_LOAD;
            state          <= S_BUSY;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            last_b         <= 1'b0;
`endif
          end else if (grant_b) begin
            b_ready        <= 1'b1;
            sdram_valid    <= 1'b1;
            sdram_address  <= b_address;
            sdram_write    <= b_write;
            sdram_wdata    <= b_wdata;
            owner_b        <= 1'b1;
            rd_outstanding <= !b_write;
            busy_cnt       <= ACC_LOAD;
            state          <= S_BUSY;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            last_b         <= 1'b1;
`endif
          end
        end
        S_BUSY: begin
          // a late read keeps the slot until its data comes back
          if (busy_cnt == '0) begin
            if (!rd_outstanding || sdram_rdata_en) state <= S_IDLE;
          end else begin
            busy_cnt <= busy_cnt - 1'b1;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_sdram_arbiter.sv
// tb/tb_ip_sdram_arbiter.sv - self-checking bench for ip_sdram_arbiter
module tb_ip_sdram_arbiter;
  localparam int AC  = 6;
  localparam int RC  = 8;
  localparam int RI  = 640;
  localparam int INF = 32'h3fffffff;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        sdram_init_busy = 1'b1;
  logic [22:0] a_address = '0, b_address = '0;
  logic        a_valid = 1'b0, a_write = 1'b0, b_valid = 1'b0, b_write = 1'b0;
  logic [7:0]  a_wdata = '0, b_wdata = '0;
  logic        a_ready, a_rdata_en, b_ready, b_rdata_en;
  logic [31:0] a_rdata, b_rdata;
  logic [22:0] sdram_address;
  logic        sdram_valid, sdram_write, sdram_refresh;
  logic [7:0]  sdram_wdata;
  logic [31:0] sdram_rdata = '0;
  logic        sdram_rdata_en = 1'b0;

  ip_sdram_arbiter #(.ACCESS_CYCLES(AC), .REFRESH_CYCLES(RC), .REFRESH_INTERVAL(RI)) dut (
    .clk(clk), .reset_n(reset_n), .sdram_init_busy(sdram_init_busy),
    .a_address(a_address), .a_valid(a_valid), .a_write(a_write), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rdata(a_rdata), .a_rdata_en(a_rdata_en),
    .b_address(b_address), .b_valid(b_valid), .b_write(b_write), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rdata(b_rdata), .b_rdata_en(b_rdata_en),
    .sdram_address(sdram_address), .sdram_valid(sdram_valid), .sdram_write(sdram_write),
    .sdram_refresh(sdram_refresh), .sdram_wdata(sdram_wdata),
    .sdram_rdata(sdram_rdata), .sdram_rdata_en(sdram_rdata_en)
  );

  always #5 clk = ~clk;

  int tot = 0, bad = 0, nprint = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // memory stand-in: read data returns rd_lat cycles after the sdram_valid cycle
  int          rd_lat = 4, mem_cnt = 0;
  logic [31:0] mem_data = '0;
  always @(posedge clk) begin
    #1;
    sdram_rdata_en = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt = mem_cnt - 1;
      if (mem_cnt == 0) begin
        sdram_rdata_en = 1'b1;
        sdram_rdata    = mem_data;
      end
    end
  end

  // event log
  int n_a_ready = 0, n_b_ready = 0, n_valid = 0, n_a_rden = 0, n_b_rden = 0;
  int a_ready_cyc = 0, b_ready_cyc = 0, a_rden_cyc = 0;
  logic [22:0] grant_addr = '0;
  int gport_q[$], gcyc_q[$], rcyc_q[$];
  always @(negedge clk) begin
    if (a_ready) begin n_a_ready++; a_ready_cyc = cyc; end
    if (b_ready) begin n_b_ready++; b_ready_cyc = cyc; end
    if (a_rdata_en) begin n_a_rden++; a_rden_cyc = cyc; end
    if (b_rdata_en) n_b_rden++;
    if (sdram_refresh) rcyc_q.push_back(cyc);
    if (sdram_valid) begin
      n_valid++;
      grant_addr = sdram_address;
      gport_q.push_back(b_ready ? 1 : 0);
      gcyc_q.push_back(cyc);
      if (reset_n && !sdram_write) mem_cnt = rd_lat;
    end
  end

  // cycle-number model: when the arbiter is next free, when the refresh timer next fires
  bit m_init, m_pend, m_rd, m_owner_b;
  int m_idle_from, m_next_exp, m_acc_end;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  bit m_last_b;
`endif
  logic        e_a_ready, e_a_rden, e_b_ready, e_b_rden, e_valid, e_write, e_refresh;
  logic [31:0] e_a_rdata, e_b_rdata;
  logic [22:0] e_addr;
  logic [7:0]  e_wdata;

  task automatic model_reset();
    m_init = 1; m_pend = 0; m_rd = 0; m_owner_b = 0;
    m_idle_from = INF; m_next_exp = INF; m_acc_end = 0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    m_last_b = 1;
`endif
    e_a_ready = 0; e_a_rden = 0; e_b_ready = 0; e_b_rden = 0;
    e_valid = 0; e_write = 0; e_refresh = 0;
    e_a_rdata = '0; e_b_rdata = '0; e_addr = '0; e_wdata = '0;
  endtask

  task automatic issue(input bit pb, input logic [22:0] ad, input logic wr, input logic [7:0] wd, input int c);
    if (pb) e_b_ready = 1; else e_a_ready = 1;
    e_valid = 1; e_addr = ad; e_write = wr; e_wdata = wd;
    m_owner_b = pb; m_rd = !wr;
    m_acc_end = c + 1 + AC;
    m_idle_from = wr ? m_acc_end : INF;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    m_last_b = pb;
`endif
  endtask

  task automatic model_step(input int c);
    bit expire, took_ref, take_a;
    e_a_ready = 0; e_b_ready = 0; e_a_rden = 0; e_b_rden = 0; e_valid = 0; e_refresh = 0;
    expire = !m_init && (c == m_next_exp);
    took_ref = 0;
    if (sdram_rdata_en && m_rd) begin
      m_rd = 0;
      if (m_owner_b) begin e_b_rdata = sdram_rdata; e_b_rden = 1; end
      else begin e_a_rdata = sdram_rdata; e_a_rden = 1; end
      m_idle_from = (m_acc_end > c + 1) ? m_acc_end : c + 1;
    end
    if (m_init) begin
      if (!sdram_init_busy) begin
        m_init = 0; m_idle_from = c + 1; m_next_exp = c + RI;
      end
    end else if (c >= m_idle_from) begin
      if (m_pend) begin
        e_refresh = 1; took_ref = 1; m_idle_from = c + 1 + RC;
      end else begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        take_a = a_valid && (!b_valid || m_last_b);
`else
        take_a = a_valid;
`endif
        if (take_a) issue(0, a_address, a_write, a_wdata, c);
        else if (b_valid) issue(1, b_address, b_write, b_wdata, c);
      end
    end
    if (expire) begin m_pend = 1; m_next_exp = c + RI; end
    else if (took_ref) m_pend = 0;
  endtask

  logic [101:0] act_v, exp_v;
  always @(negedge clk) begin
    if (!reset_n) model_reset();
    act_v = {a_ready, a_rdata_en, a_rdata, b_ready, b_rdata_en, b_rdata,
             sdram_address, sdram_valid, sdram_write, sdram_refresh, sdram_wdata};
    exp_v = {e_a_ready, e_a_rden, e_a_rdata, e_b_ready, e_b_rden, e_b_rdata,
             e_addr, e_valid, e_write, e_refresh, e_wdata};
    tot++;
    if (act_v !== exp_v) begin
      bad++;
      if (nprint < 20) $display("FAIL cycle_outputs @%0d: got %h expected %h", cyc, act_v, exp_v);
      nprint++;
    end
    if (reset_n) model_step(cyc);
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    tot++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int f, g, base, k, p, bref, bg;
    int exp_p;
    #2 reset_n = 0;
    a_valid = 1; a_write = 1; a_address = 23'h000055; a_wdata = 8'h5A;
    repeat (3) tick();
    chk("reset_outputs_zero", longint'(act_v != '0), 0);
    reset_n = 1;

    // init hold, then first grant two cycles after busy falls
    repeat (100) tick();
    chk("init_no_ready", n_a_ready, 0);
    chk("init_no_valid", n_valid, 0);
    sdram_init_busy = 0;
    f = cyc;
    k = 0;
    while (n_a_ready == 0 && k < 20) begin tick(); k++; end
    a_valid = 0;
    chk("init_grant_seen", longint'(n_a_ready > 0), 1);
    chk("init_latency", a_ready_cyc - f, 2);
    if (gport_q.size() > 0) chk("init_first_port", gport_q[0], 0);
    else chk("init_first_port", -1, 0);

    // A read with data 4 cycles after the command, then B write waits for the slot
    tick();
    rd_lat = 4; mem_data = 32'hDEADBEEF;
    a_address = 23'h000123; a_write = 0; a_valid = 1;
    base = n_a_ready; k = 0;
    while (n_a_ready == base && k < 20) begin tick(); k++; end
    g = a_ready_cyc;
    a_valid = 0;
    chk("rd_addr", grant_addr, 23'h000123);
    b_address = 23'h000456; b_write = 1; b_wdata = 8'hB1; b_valid = 1;
    base = n_a_rden; k = 0;
    while (n_a_rden == base && k < 20) begin tick(); k++; end
    chk("rd_latency", a_rden_cyc - g, 5);
    chk("rd_data", a_rdata, 32'hDEADBEEF);
    chk("rd_b_quiet", n_b_rden, 0);
    base = n_b_ready; k = 0;
    while (n_b_ready == base && k < 20) begin tick(); k++; end
    b_valid = 0;
    chk("b_after_read", b_ready_cyc - g, AC + 1);

    // both ports requesting continuously
    tick();
    a_address = 23'h000100; a_write = 1; a_wdata = 8'h11; a_valid = 1;
    b_address = 23'h000200; b_write = 1; b_wdata = 8'h22; b_valid = 1;
    base = gcyc_q.size(); k = 0;
    while (gcyc_q.size() < base + 4 && k < 100) begin tick(); k++; end
    a_valid = 0; b_valid = 0;
    chk("contend_grants", longint'(gcyc_q.size() >= base + 4), 1);
    if (gcyc_q.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        exp_p = i % 2;
`else
        exp_p = 0;
`endif
        chk($sformatf("contend_port%0d", i), gport_q[base + i], exp_p);
        if (i > 0) chk($sformatf("contend_gap%0d", i), gcyc_q[base + i] - gcyc_q[base + i - 1], AC + 1);
      end
    end

    // idle: refresh every RI cycles; a stray init_busy pulse must not matter
    base = n_valid;
    repeat (10) tick();
    sdram_init_busy = 1;
    repeat (5) tick();
    sdram_init_busy = 0;
    k = 0;
    while (rcyc_q.size() < 3 && k < 2500) begin tick(); k++; end
    chk("idle_refresh_count", longint'(rcyc_q.size() >= 3), 1);
    chk("idle_no_valid", n_valid - base, 0);
    if (rcyc_q.size() >= 3) begin
      chk("first_refresh", rcyc_q[0] - f, RI + 2);
      chk("refresh_period1", rcyc_q[1] - rcyc_q[0], 640);
      chk("refresh_period2", rcyc_q[2] - rcyc_q[1], 640);
    end

    // requests arrive in the cycle refresh_pending is first visible
    p = (rcyc_q.size() > 0) ? rcyc_q[rcyc_q.size() - 1] : cyc;
    k = 0;
    while (cyc < p + RI - 1 && k < 700) begin tick(); k++; end
    a_address = 23'h000300; a_wdata = 8'h33; a_valid = 1;
    b_address = 23'h000400; b_wdata = 8'h44; b_valid = 1;
    bref = rcyc_q.size(); bg = gcyc_q.size(); k = 0;
    while (gcyc_q.size() == bg && k < 30) begin tick(); k++; end
    a_valid = 0;
    if (rcyc_q.size() > bref && gcyc_q.size() > bg) begin
      chk("pend_refresh_cycle", rcyc_q[bref] - p, RI);
      chk("pend_winner_port", gport_q[bg], 0);
      chk("pend_grant_gap", gcyc_q[bg] - rcyc_q[bref], RC + 1);
    end else chk("pend_events_seen", 0, 1);
    k = 0;
    while (gcyc_q.size() < bg + 2 && k < 30) begin tick(); k++; end
    b_valid = 0;
    if (gcyc_q.size() >= bg + 2) begin
      chk("pend_loser_port", gport_q[bg + 1], 1);
      chk("pend_loser_gap", gcyc_q[bg + 1] - gcyc_q[bg], AC + 1);
    end else chk("pend_loser_seen", 0, 1);

    // late read data holds the slot
    tick();
    rd_lat = AC + 3; mem_data = 32'h0BADF00D;
    a_address = 23'h0003C0; a_write = 0; a_valid = 1;
    base = n_a_ready; k = 0;
    while (n_a_ready == base && k < 20) begin tick(); k++; end
    g = a_ready_cyc;
    a_valid = 0;
    b_address = 23'h0003C4; b_write = 1; b_wdata = 8'h55; b_valid = 1;
    base = n_a_rden; k = 0;
    while (n_a_rden == base && k < 30) begin tick(); k++; end
    chk("late_rd_latency", a_rden_cyc - g, AC + 4);
    chk("late_rd_data", a_rdata, 32'h0BADF00D);
    base = n_b_ready; k = 0;
    while (n_b_ready == base && k < 30) begin tick(); k++; end
    b_valid = 0;
    chk("late_b_gap", b_ready_cyc - g, AC + 5);

    // reset in the middle of an outstanding read
    tick();
    mem_data = 32'h12345678;
    a_address = 23'h000777; a_write = 0; a_valid = 1;
    base = n_a_ready; k = 0;
    while (n_a_ready == base && k < 20) begin tick(); k++; end
    a_valid = 0;
    tick(); tick();
    reset_n = 0;
    #1;
    chk("midreset_outputs_zero", longint'({a_ready, a_rdata, sdram_address, sdram_valid, sdram_write, sdram_wdata} != '0), 0);
    tick(); tick();
    reset_n = 1;
    base = n_a_rden;
    repeat (15) tick();
    chk("midreset_no_rdata_en", n_a_rden - base, 0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
